ps2_kbd_responder: RTL and testbench
====================================

// Module: ps2_kbd_responder
// PURPOSE
//  Keyboard-side peripheral behind the 0xD region of the MIO bus.
//  Deserialises PS/2 device-to-host frames and queues valid scancodes in a FIFO.
//  Presents the FIFO head as the 10-bit ps2kb_key word; a CPU read of region 0xD pops one entry.
//  Receive-only; no host-to-device transmission.
// PARAMETERS
//  FIFO_DEPTH  8      entries; power of two, >=2
//  TIMEOUT     50000  clk cycles allowed between PS/2 falling edges inside a frame (1 ms @ 50 MHz)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  ps2_clk      in   1   raw PS/2 clock from pin (asynchronous)
//  ps2_data     in   1   raw PS/2 data from pin (asynchronous)
//  rd           in   1   pop strobe: 1-cycle pulse = CPU read of 0xD region (ps2kb_rd && bus cycle)
//  ps2kb_key    out  10  {valid, overflow, code[7:0]}
//  parity_err   out  1   1-cycle pulse when a frame is discarded for bad parity or stop bit
// BEHAVIOUR
//  Sync:
//  - ps2_clk and ps2_data each pass through 2 flops.
//  - A falling edge is detected from the synced clock plus one more flop: prev=1, cur=0.
//  - The edge samples synced data in the same cycle.
//  Frame: start(0), d0..d7 LSB first, odd parity, stop(1); 11 falling edges.
//  FSM states: IDLE, DATA, PARITY, STOP.
//  - IDLE: on edge, data=0 -> DATA with bit count 0; data=1 -> remain IDLE (glitch ignored).
//  - DATA: shift a bit in on each edge; after the 8th bit -> PARITY.
//  - PARITY: latch the bit -> STOP.
//  - STOP: on edge -> IDLE always.
//    - Frame is good only if ^{d7..d0,parity}==1 and stop==1.
//    - Good frame: push code.
//    - Bad frame: no push; parity_err=1 for that one cycle.
//  Timeout:
//  - A counter is reset on every edge and increments while FSM != IDLE.
//  - Reaching TIMEOUT-1 -> IDLE; the partial frame is dropped silently; no parity_err.
//  Push timing: the FIFO write occurs on the cycle after the stop-bit edge; visible on ps2kb_key the next cycle.
//  FIFO: circular, with rd/wr pointers plus count.
//  - ps2kb_key[7:0] = head entry when count>0, else 8'h00.
//  - ps2kb_key[9] (valid) = count!=0.
//  - rd while empty: ignored; no state change.
//  - rd while non-empty: pop; the new head appears the following cycle.
//  - Push while full without same-cycle pop: byte dropped; overflow set.
//  - Push and pop in the same cycle: both occur; count unchanged; no overflow, even when full.
//  - Push into empty with same-cycle rd: rd ignored (empty); push occurs.
//  Overflow:
//  - ps2kb_key[8] is sticky.
//  - Cleared by any accepted pop.
//  - A set and a clear in the same cycle: set wins.
//  Reset (rst=1 at clk edge):
//  - FSM=IDLE; bit count, shift register, timeout counter = 0.
//  - FIFO emptied; overflow=0; parity_err=0.
//  - ps2kb_key = 10'h000.
//  - Sync flops reset to 1 (bus idle-high), so no false edge is seen after reset.
//  - Reset mid-frame discards the frame; the remaining edges of that frame start with a data bit.
//    They are treated per IDLE rules and will self-correct via the start-bit check and timeout.
//  Widths:
//  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//  - count is log2(FIFO_DEPTH)+1 bits.
// TESTING
//  1. Send frame code 8'h1C, parity 0 ->
//     ps2kb_key=10'h21C within 2 cycles of the stop edge; parity_err stays 0.
//  2. Send 8'h1C with parity 1 ->
//     parity_err pulses 1 cycle; ps2kb_key stays 10'h000.
//  3. Send 9 good frames 8'h01..8'h09, no rd (depth 8) ->
//     ps2kb_key=10'h301; after 8 rd pulses, codes 01..08 are read in order.
//     First pop clears overflow (10'h202 next); the final state is 10'h000.
//  4. Send start + 4 data bits, then idle > TIMEOUT cycles; then a full frame 8'hF0 ->
//     only 10'h2F0 is queued; parity_err never asserted.
//  5. With the FIFO full, issue rd in the same cycle as a push of 8'hAA ->
//     count stays 8; overflow stays 0; 8'hAA becomes the last entry.
//  6. Assert rst after the 5th data edge, release, then send frame 8'h5A ->
//     ps2kb_key=10'h000 during and after reset.
//     Eventually only 10'h25A is queued; no stale byte appears.

Source files
------------

// File: rtl/ps2_kbd_responder_if.sv
// CPU-side port bundle of the PS/2 keyboard responder: pop strobe, key word and the parity-error pulse.
interface ps2_kbd_responder_if;
    logic       rd;
    logic [9:0] ps2kb_key;
    logic       parity_err;

    modport master (output rd, input ps2kb_key, input parity_err);
    modport slave  (input rd, output ps2kb_key, output parity_err);
endinterface

// File: rtl/ps2_kbd_responder.sv
// Receive-only PS/2 keyboard deserialiser feeding a scancode FIFO that is read (and popped) by the CPU
// through the 0xD MIO region.
module ps2_kbd_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_kbd_responder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    push_code_q, push_code_d;
    logic          perr_q, perr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic fall, bit_in, pop, full, push_ok;

    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_prev_d  = clk_s2_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        fall        = clk_prev_q & ~clk_s2_q;
        bit_in      = dat_s2_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        perr_d      = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = bit_in;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if ((^{shift_q, parity_q}) && bit_in) begin
                        push_d      = 1'b1;
                        push_code_d = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A stalled frame is abandoned quietly so the next start bit resynchronises us.
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pop      = bus.rd && (count_q != '0);
        full     = (count_q == (PW+1)'(FIFO_DEPTH));
        // When full, a same-cycle pop frees the slot the write lands in, so the push is still accepted.
        push_ok  = push_q && (!full || pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_code_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        if (pop) ovf_d = 1'b0;
        if (push_q && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            perr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            perr_q      <= perr_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.ps2kb_key  = {count_q != '0, ovf_q, (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00};
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_ps2_kbd_responder.sv
// Directed bench for ps2_kbd_responder: bit-bangs PS/2 frames and checks the key word, pops and error pulses.
module tb_ps2_kbd_responder;
    localparam int TMO = 500;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    int   checkCount = 0;
    int   passCount  = 0;
    int   perrCycles = 0;
    int   perrBase;

    ps2_kbd_responder_if bus_if ();

    ps2_kbd_responder #(.FIFO_DEPTH(8), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && bus_if.parity_err) perrCycles++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic ps2Bit(input logic b);
        ps2_data = b;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Sends bits firstBit..lastBit of the 11-bit frame {stop, parity, code, start}.
    task automatic applyStimulus(input logic [7:0] code, input logic flip, input logic stopBit,
                                 input int firstBit, input int lastBit);
        logic [10:0] f;
        f = {stopBit, (~^code) ^ flip, code, 1'b0};
        for (int i = firstBit; i <= lastBit; i++) ps2Bit(f[i]);
    endtask

    task automatic finishStop(input logic doRd, input string tag,
                              input logic [9:0] expBefore, input logic [9:0] expAfter);
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput({tag, "_before"}, 32'(bus_if.ps2kb_key), 32'(expBefore));
        if (doRd) bus_if.rd = 1'b1;
        @(posedge clk);
        #1 bus_if.rd = 1'b0;
        checkOutput({tag, "_after"}, 32'(bus_if.ps2kb_key), 32'(expAfter));
        repeat (6) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic popOnce(input string tag, input logic [9:0] expAfter);
        bus_if.rd = 1'b1;
        @(posedge clk);
        #1 bus_if.rd = 1'b0;
        checkOutput(tag, 32'(bus_if.ps2kb_key), 32'(expAfter));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        bus_if.rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_key", 32'(bus_if.ps2kb_key), 32'h000);
        checkOutput("reset_perr", 32'(bus_if.parity_err), 32'h0);

        // Good frame with exact push latency
        perrBase = perrCycles;
        applyStimulus(8'h1C, 1'b0, 1'b1, 0, 9);
        finishStop(1'b0, "t1_latency", 10'h000, 10'h21C);
        checkOutput("t1_perr", 32'(perrCycles - perrBase), 32'd0);
        popOnce("t1_pop", 10'h000);

        // Bad parity, then bad stop bit
        perrBase = perrCycles;
        applyStimulus(8'h1C, 1'b1, 1'b1, 0, 10);
        checkOutput("t2_parity_key", 32'(bus_if.ps2kb_key), 32'h000);
        checkOutput("t2_parity_pulse", 32'(perrCycles - perrBase), 32'd1);
        perrBase = perrCycles;
        applyStimulus(8'h1C, 1'b0, 1'b0, 0, 10);
        checkOutput("t2_stop_key", 32'(bus_if.ps2kb_key), 32'h000);
        checkOutput("t2_stop_pulse", 32'(perrCycles - perrBase), 32'd1);

        // Overflow: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b1, 0, 10);
        checkOutput("t3_full_ovf", 32'(bus_if.ps2kb_key), 32'h301);
        for (int i = 2; i <= 8; i++) popOnce("t3_pop", {2'b10, 8'(i)});
        popOnce("t3_pop_last", 10'h000);
        popOnce("t3_pop_empty", 10'h000);

        // Partial frame abandoned by timeout
        perrBase = perrCycles;
        applyStimulus(8'hC5, 1'b0, 1'b1, 0, 4);
        repeat (TMO + 100) @(posedge clk);
        #1 checkOutput("t4_dropped", 32'(bus_if.ps2kb_key), 32'h000);
        applyStimulus(8'hF0, 1'b0, 1'b1, 0, 10);
        checkOutput("t4_key", 32'(bus_if.ps2kb_key), 32'h2F0);
        checkOutput("t4_perr", 32'(perrCycles - perrBase), 32'd0);
        popOnce("t4_pop", 10'h000);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b0, 1'b1, 0, 10);
        checkOutput("t5_full", 32'(bus_if.ps2kb_key), 32'h210);
        applyStimulus(8'hAA, 1'b0, 1'b1, 0, 9);
        finishStop(1'b1, "t5_pushpop", 10'h210, 10'h211);
        for (int i = 2; i <= 7; i++) popOnce("t5_pop", {2'b10, 8'h10 + 8'(i)});
        popOnce("t5_pop_aa", 10'h2AA);
        popOnce("t5_pop_last", 10'h000);

        // Reset in the middle of a frame
        applyStimulus(8'h77, 1'b0, 1'b1, 0, 10);
        checkOutput("t6_pre", 32'(bus_if.ps2kb_key), 32'h277);
        perrBase = perrCycles;
        applyStimulus(8'h33, 1'b0, 1'b1, 0, 5);
        rst = 1'b1;
        @(posedge clk);
        #1 checkOutput("t6_in_reset", 32'(bus_if.ps2kb_key), 32'h000);
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("t6_after_reset", 32'(bus_if.ps2kb_key), 32'h000);
        applyStimulus(8'h33, 1'b0, 1'b1, 6, 10);
        repeat (TMO + 100) @(posedge clk);
        #1 checkOutput("t6_no_stale", 32'(bus_if.ps2kb_key), 32'h000);
        applyStimulus(8'h5A, 1'b0, 1'b1, 0, 10);
        checkOutput("t6_key", 32'(bus_if.ps2kb_key), 32'h25A);
        checkOutput("t6_perr", 32'(perrCycles - perrBase), 32'd0);
        popOnce("t6_pop", 10'h000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
